druaga_rom_loader: RTL and testbench
====================================

# druaga_rom_loader

Sequential ROM download front-end between the HPS ioctl stream and the game core's ROM write port (ROMAD/ROMDT/ROMEN) and MODEL select. It does four things:
- Latches the title number.
- Re-registers ROM bytes with one-cycle latency.
- Checks that the image arrived contiguous and complete (optionally checksummed).
- Holds the core in reset until a valid image is loaded.

## Interface
Parameters:
- AW, 18, ROM address width driven to the core
- ROM_SIZE, 18'h2C000, exact image byte count expected on index 0
- EXP_SUM, 8'h00, expected 8-bit modular sum of all image bytes (used only with ROM_CHECKSUM_EN)

Ports:
- MCLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- ioctl_download  in  1  HPS download active
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_index  in  8  0 = ROM image, 1 = title number
- ioctl_addr  in  25  byte address within the current download
- ioctl_dout  in  8  byte data
- ROMAD  out  AW  registered ROM write address
- ROMDT  out  8  registered ROM write data
- ROMEN  out  1  one-cycle ROM write strobe
- MODEL  out  3  title/system select to the core
- core_rst  out  1  reset request to the core
- load_ok  out  1  last index-0 download valid
- load_err  out  1  last index-0 download invalid

## Operation
- Reset values: ROMAD=0, ROMDT=0, ROMEN=0, MODEL=0, core_rst=1, load_ok=0, load_err=0. Also cnt=0, sum=0, gap=0, ovf=0, dl_d=0, state=IDLE.
- States: IDLE, LOAD, CHECK, DONE, ERR.
- Rising edge of download (dl_d=0, ioctl_download=1) with ioctl_index=0, from any state:
  - go to LOAD;
  - clear cnt, sum, gap, ovf, load_ok, load_err.
- LOAD, ioctl_wr=1 with index 0:
  - addr ≥ ROM_SIZE: set ovf; no ROMEN.
  - Otherwise, if addr ≠ cnt: set gap.
  - Either way (addr < ROM_SIZE): ROMAD←addr[AW-1:0], ROMDT←dout, ROMEN←1, cnt←cnt+1, sum←sum+dout (mod 256).
- Writes are accepted only while ioctl_download=1. ioctl_wr in any state other than LOAD produces no ROMEN.
- Index 1: ioctl_wr with addr=0 in any state sets MODEL←dout[2:0]. Other addresses are ignored.
- Falling edge of download in LOAD → CHECK.
- CHECK (exactly one cycle) evaluates pass = (cnt==ROM_SIZE) & ~gap & ~ovf [& (sum==EXP_SUM)]:
  - pass → DONE with load_ok=1;
  - fail → ERR with load_err=1.
- core_rst:
  - 1 whenever ioctl_download=1, for any index;
  - 1 in IDLE, LOAD, CHECK, ERR;
  - 0 only in DONE with ioctl_download=0.
- A download with index ≠ 0 does not change state. core_rst rises for its duration and returns to 0 afterwards if the state is DONE.
- cnt saturates at ROM_SIZE; further in-range bytes are impossible because of the ovf rule.

## Timing
- ROMEN/ROMAD/ROMDT appear one cycle after the sampled ioctl_wr. ROMEN is high for exactly one cycle per accepted byte.
- Back-to-back ioctl_wr on consecutive cycles is supported: one ROMEN per cycle, no drops.
- Fall sampled at edge N → CHECK after edge N. DONE/ERR and load_ok/load_err after edge N+1. core_rst falls after edge N+1 on pass.
- Same-cycle rising download and ioctl_wr: the byte is processed as the first byte of the new load (cnt=0 reference).
- RESET asserted mid-LOAD:
  - immediately forces all reset values and state IDLE;
  - writes after RESET release are ignored until a new download rising edge.
- Rising edge while in CHECK: treated as a restart. LOAD wins; the CHECK result is discarded.

## Configuration
- ROM_CHECKSUM_EN defined: the sum accumulator is built, and sum≠EXP_SUM at CHECK forces ERR.
- ROM_CHECKSUM_EN undefined: no accumulator is synthesized, EXP_SUM is ignored, and pass depends only on count, gap and ovf.

## Test plan
All scenarios use ROM_SIZE=16 and EXP_SUM=8'h78 (sum of bytes 0..15).
- Contiguous load: bytes 0..15 at addr 0..15, then download low.
  - 16 ROMEN pulses, each ROMAD=ROMDT one cycle after its wr.
  - load_ok=1 and core_rst=0 two edges after the fall.
- Short image (addr 0..14 only): load_err=1, load_ok=0, core_rst stays 1.
- Gap (addr 0..4, 6..16 sent): gap set, load_err=1; addr 16 raises ovf and produces no ROMEN.
- Checksum: byte 3 changed 03→04.
  - With ROM_CHECKSUM_EN: load_err=1.
  - Without it: load_ok=1.
- Index-1 download writes 8'h05 at addr 0, then a good index-0 load: MODEL=3'd5 throughout the second load. core_rst is 1 during both downloads and 0 afterwards.
- RESET pulse after byte 7:
  - all outputs return to reset values, state IDLE;
  - remaining bytes produce no ROMEN;
  - a fresh full load then passes.

Source files
------------

// File: rtl/druaga_rom_loader.sv
`timescale 1ns/1ps
// druaga_rom_loader
// Sits between the HPS ioctl download stream and the game core's ROM write port.
// It latches the title number (MODEL) and re-registers ROM bytes onto ROMAD/ROMDT/ROMEN
// with one cycle of latency. It checks that the index-0 image arrived contiguous and
// complete, and holds the core in reset until a valid image has been loaded.
// Optional feature: define ROM_CHECKSUM_EN to build the 8-bit modular image checksum,
// which must equal EXP_SUM for the image to be accepted.
module druaga_rom_loader #(
  parameter int unsigned AW       = 18,
  parameter logic [24:0] ROM_SIZE = 25'h2C000,
  parameter logic [7:0]  EXP_SUM  = 8'h00
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [AW-1:0] ROMAD,
  output logic [7:0]    ROMDT,
  output logic          ROMEN,
  output logic [2:0]    MODEL,
  output logic          core_rst,
  output logic          load_ok,
  output logic          load_err
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_dlD;
  logic        r_rstHold;
  logic [24:0] r_cnt;
  logic        r_gap;
  logic        r_ovf;

  logic        w_rise;
  logic        w_riseRom;
  logic        w_fall;
  logic        w_wrRom;
  logic        w_inRange;
  logic        w_pass;
  logic        w_sumOk;
  logic [24:0] w_cntBase;

  // A download that was already running when RESET released must not look like a
  // fresh start, so rising edges are ignored until download has been seen low once.
  assign w_rise    = ioctl_download & ~r_dlD & ~r_rstHold;
  assign w_riseRom = w_rise & (ioctl_index == 8'd0);
  assign w_fall    = ~ioctl_download & r_dlD;
  assign w_inRange = (ioctl_addr < ROM_SIZE);

  // A byte arriving on the same cycle as the rising edge is the first byte of the new load.
  assign w_wrRom   = ioctl_wr & ioctl_download & (ioctl_index == 8'd0) &
                     ((r_state == LOAD) | w_riseRom);
  assign w_cntBase = w_riseRom ? 25'd0 : r_cnt;

`ifdef ROM_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sumBase;

  assign w_sumBase = w_riseRom ? 8'd0 : r_sum;
  assign w_sumOk   = (r_sum == EXP_SUM);

  // Running modulo-256 sum of every accepted image byte, restarted by each new load.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)                      r_sum <= 8'd0;
    else if (w_wrRom && w_inRange)  r_sum <= w_sumBase + ioctl_dout;
    else if (w_riseRom)             r_sum <= 8'd0;
  end
`else
  // EXP_SUM has no effect in this build; the OR only keeps the parameter referenced.
  assign w_sumOk = 1'b1 | (|EXP_SUM);
`endif

  assign w_pass = (r_cnt == ROM_SIZE) & ~r_gap & ~r_ovf & w_sumOk;

  // Download edge tracking and the post-reset hold-off.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_dlD     <= 1'b0;
      r_rstHold <= 1'b1;
    end else begin
      r_dlD     <= ioctl_download;
      r_rstHold <= r_rstHold & ioctl_download;
    end
  end

  // State register.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and core reset request; a new index-0 download restarts from any state.
  always_comb begin
    w_nextState = r_state;
    core_rst    = ioctl_download | (r_state != DONE);
    if (w_riseRom) begin
      w_nextState = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_fall) w_nextState = CHECK;
        CHECK:   w_nextState = w_pass ? DONE : ERR;
        default: ;
      endcase
    end
  end

  // ROM write port, byte count and the gap/overflow flags for the current image.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      ROMAD <= '0;
      ROMDT <= 8'd0;
      ROMEN <= 1'b0;
      r_cnt <= 25'd0;
      r_gap <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      ROMEN <= 1'b0;
      if (w_riseRom) begin
        r_cnt <= 25'd0;
        r_gap <= 1'b0;
        r_ovf <= 1'b0;
      end
      if (w_wrRom) begin
        if (!w_inRange) begin
          r_ovf <= 1'b1;
        end else begin
          if (ioctl_addr != w_cntBase) r_gap <= 1'b1;
          ROMAD <= ioctl_addr[AW-1:0];
          ROMDT <= ioctl_dout;
          ROMEN <= 1'b1;
          r_cnt <= (w_cntBase == ROM_SIZE) ? ROM_SIZE : w_cntBase + 25'd1;
        end
      end
    end
  end

  // Verdict flags: cleared by a new load, set from the one-cycle CHECK evaluation.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else if (w_riseRom) begin
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else if (r_state == CHECK) begin
      load_ok  <= w_pass;
      load_err <= ~w_pass;
    end
  end

  // Title number: byte 0 of an index-1 download, accepted in any state.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      MODEL <= 3'd0;
    end else if (ioctl_download && ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
      MODEL <= ioctl_dout[2:0];
    end
  end

endmodule

// File: tb/tb_druaga_rom_loader.sv
`timescale 1ns/1ps
// tb_druaga_rom_loader
// Directed scenarios plus randomized loads for druaga_rom_loader with ROM_SIZE=16.
// The reference model keeps the list of accepted byte addresses and the byte sum,
// and it judges each finished image from that list.
module tb_druaga_rom_loader;

  localparam int          AW       = 18;
  localparam logic [24:0] ROM_SIZE = 25'd16;
  localparam logic [7:0]  EXP_SUM  = 8'h78;
`ifdef ROM_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          MCLK = 1'b0;
  logic          RESET = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic [AW-1:0] ROMAD;
  logic [7:0]    ROMDT;
  logic          ROMEN;
  logic [2:0]    MODEL;
  logic          core_rst;
  logic          load_ok;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       mLoading, mPending, mOk, mErr, mOvf, mPrevDl;
  logic [2:0] mModel;
  int       mAddrs[$];
  int       mSum;
  int       romenSeen;
  int       qAddr[$];
  int       qData[$];

  druaga_rom_loader #(.AW(AW), .ROM_SIZE(ROM_SIZE), .EXP_SUM(EXP_SUM)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN), .MODEL(MODEL),
    .core_rst(core_rst), .load_ok(load_ok), .load_err(load_err)
  );

  // 100 MHz system clock
  always #5 MCLK = ~MCLK;

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // An image is good when it holds exactly addresses 0..15 in order, nothing out of range,
  // and (with the checksum built) bytes summing to EXP_SUM modulo 256.
  function automatic bit imageGood();
    if (mOvf || mAddrs.size() != 16) return 1'b0;
    for (int i = 0; i < mAddrs.size(); i++)
      if (mAddrs[i] != i) return 1'b0;
    if (CK && ((mSum % 256) != int'(EXP_SUM))) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, advance the model, then check every output after the edge.
  task automatic applyStimulus(input logic dl, input logic [7:0] idx, input logic wr,
                               input int addr, input logic [7:0] dout);
    bit rise;
    bit accept;
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = 25'(addr);
    ioctl_dout     = dout;
    if (mPending) begin
      mPending = 1'b0;
      if (imageGood()) mOk = 1'b1;
      else             mErr = 1'b1;
    end
    rise = dl && !mPrevDl;
    if (rise && idx == 8'd0) begin
      mLoading = 1'b1;
      mAddrs.delete();
      mSum = 0;
      mOvf = 1'b0;
      mOk  = 1'b0;
      mErr = 1'b0;
    end
    accept = 1'b0;
    if (mLoading && dl && wr && idx == 8'd0) begin
      if (addr >= 16) mOvf = 1'b1;
      else begin
        accept = 1'b1;
        mAddrs.push_back(addr);
        mSum += int'(dout);
      end
    end
    if (dl && wr && idx == 8'd1 && addr == 0) mModel = dout[2:0];
    if (mLoading && !dl && mPrevDl) begin
      mLoading = 1'b0;
      mPending = 1'b1;
    end
    mPrevDl = dl;
    @(posedge MCLK);
    #1;
    checkOutput("ROMEN", 32'(ROMEN), 32'(accept));
    if (accept) begin
      romenSeen++;
      checkOutput("ROMAD", 32'(ROMAD), 32'(addr));
      checkOutput("ROMDT", 32'(ROMDT), 32'(dout));
    end
    checkOutput("MODEL", 32'(MODEL), 32'(mModel));
    checkOutput("load_ok", 32'(load_ok), 32'(mOk));
    checkOutput("load_err", 32'(load_err), 32'(mErr));
    checkOutput("core_rst", 32'(core_rst), 32'(dl || !mOk));
  endtask

  task automatic pulseReset();
    ioctl_wr = 1'b0;
    RESET = 1'b1;
    #1;
    checkOutput("rst_ROMAD", 32'(ROMAD), 32'd0);
    checkOutput("rst_ROMDT", 32'(ROMDT), 32'd0);
    checkOutput("rst_ROMEN", 32'(ROMEN), 32'd0);
    checkOutput("rst_MODEL", 32'(MODEL), 32'd0);
    checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("rst_load_ok", 32'(load_ok), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    mLoading = 1'b0;
    mPending = 1'b0;
    mOk      = 1'b0;
    mErr     = 1'b0;
    mModel   = 3'd0;
    mPrevDl  = 1'b1;
    @(posedge MCLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic makeImage(input int n);
    qAddr.delete();
    qData.delete();
    for (int i = 0; i < n; i++) begin
      qAddr.push_back(i);
      qData.push_back(i);
    end
  endtask

  task automatic startDl(input logic [7:0] idx, input bit firstWr);
    int a;
    int d;
    if (firstWr && qAddr.size() > 0) begin
      a = qAddr.pop_front();
      d = qData.pop_front();
      applyStimulus(1'b1, idx, 1'b1, a, 8'(d));
    end else begin
      applyStimulus(1'b1, idx, 1'b0, 0, 8'd0);
    end
  endtask

  task automatic sendBytes(input logic [7:0] idx, input int maxIdle);
    int a;
    int d;
    while (qAddr.size() > 0) begin
      repeat ($urandom_range(maxIdle, 0)) applyStimulus(1'b1, idx, 1'b0, 0, 8'd0);
      a = qAddr.pop_front();
      d = qData.pop_front();
      applyStimulus(1'b1, idx, 1'b1, a, 8'(d));
    end
  endtask

  task automatic endDl(input logic [7:0] idx);
    applyStimulus(1'b1, idx, 1'b0, 0, 8'd0);
    applyStimulus(1'b0, idx, 1'b0, 0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 0, 8'd0);
  endtask

  task automatic runDownload(input logic [7:0] idx, input bit firstWr, input int maxIdle);
    startDl(idx, firstWr);
    sendBytes(idx, maxIdle);
    endDl(idx);
  endtask

  initial begin
    int s;
    int k;
    int mut;
    mModel = 3'd0;
    #2;
    pulseReset();
    applyStimulus(1'b0, 8'd0, 1'b0, 0, 8'd0);

    // Contiguous image, back-to-back bytes
    makeImage(16);
    romenSeen = 0;
    runDownload(8'd0, 1'b0, 0);
    checkOutput("contig_romen_count", 32'(romenSeen), 32'd16);
    checkOutput("contig_ok", 32'(load_ok), 32'd1);
    checkOutput("contig_core_rst", 32'(core_rst), 32'd0);

    // Short image
    makeImage(15);
    runDownload(8'd0, 1'b0, 1);
    checkOutput("short_err", 32'(load_err), 32'd1);
    checkOutput("short_ok", 32'(load_ok), 32'd0);
    checkOutput("short_core_rst", 32'(core_rst), 32'd1);

    // Gap at address 5 plus one out-of-range byte at 16
    qAddr.delete();
    qData.delete();
    for (int i = 0; i <= 16; i++) begin
      if (i != 5) begin
        qAddr.push_back(i);
        qData.push_back(i);
      end
    end
    romenSeen = 0;
    runDownload(8'd0, 1'b0, 0);
    checkOutput("gap_romen_count", 32'(romenSeen), 32'd15);
    checkOutput("gap_err", 32'(load_err), 32'd1);

    // Corrupted byte 3 only matters when the checksum is built
    makeImage(16);
    qData[3] = 4;
    runDownload(8'd0, 1'b0, 0);
    checkOutput("cksum_ok", 32'(load_ok), 32'(!CK));
    checkOutput("cksum_err", 32'(load_err), 32'(CK));

    // Title number, then a good image; address 1 of index 1 is ignored
    qAddr = '{0, 1};
    qData = '{5, 7};
    runDownload(8'd1, 1'b0, 0);
    checkOutput("title_model", 32'(MODEL), 32'd5);
    makeImage(16);
    runDownload(8'd0, 1'b0, 0);
    checkOutput("title_load_ok", 32'(load_ok), 32'd1);
    checkOutput("title_model_after", 32'(MODEL), 32'd5);
    checkOutput("title_core_rst", 32'(core_rst), 32'd0);

    // RESET after byte 7, remaining bytes dropped, then a fresh full load
    makeImage(8);
    startDl(8'd0, 1'b0);
    sendBytes(8'd0, 0);
    pulseReset();
    qAddr.delete();
    qData.delete();
    for (int i = 8; i < 16; i++) begin
      qAddr.push_back(i);
      qData.push_back(i);
    end
    romenSeen = 0;
    sendBytes(8'd0, 0);
    endDl(8'd0);
    checkOutput("rst_romen_count", 32'(romenSeen), 32'd0);
    checkOutput("rst_idle_ok", 32'(load_ok), 32'd0);
    checkOutput("rst_idle_err", 32'(load_err), 32'd0);
    checkOutput("rst_idle_core_rst", 32'(core_rst), 32'd1);
    makeImage(16);
    runDownload(8'd0, 1'b0, 0);
    checkOutput("rst_reload_ok", 32'(load_ok), 32'd1);

    // First byte on the same cycle as the rising edge
    makeImage(16);
    runDownload(8'd0, 1'b1, 1);
    checkOutput("samecycle_ok", 32'(load_ok), 32'd1);

    // Restart while in CHECK discards the short image's verdict
    makeImage(15);
    startDl(8'd0, 1'b0);
    sendBytes(8'd0, 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 0, 8'd0);
    applyStimulus(1'b1, 8'd0, 1'b0, 0, 8'd0);
    checkOutput("restart_err", 32'(load_err), 32'd0);
    makeImage(16);
    sendBytes(8'd0, 0);
    endDl(8'd0);
    checkOutput("restart_ok", 32'(load_ok), 32'd1);

    // Randomized images with mutations and occasional title writes
    for (int it = 0; it < 24; it++) begin
      qAddr.delete();
      qData.delete();
      s = 0;
      for (int i = 0; i < 16; i++) begin
        qAddr.push_back(i);
        k = int'($urandom_range(255, 0));
        qData.push_back(k);
        if (i < 15) s += k;
      end
      if ($urandom_range(1, 0) == 1) qData[15] = (120 - s) & 255;
      mut = int'($urandom_range(4, 0));
      k = int'($urandom_range(15, 0));
      case (mut)
        1: begin qAddr.delete(k); qData.delete(k); end
        2: qAddr[k] = int'($urandom_range(20, 0));
        3: begin qAddr.push_back(16 + int'($urandom_range(7, 0))); qData.push_back(1); end
        4: begin s = qAddr[k]; qAddr[k] = qAddr[15 - k]; qAddr[15 - k] = s; end
        default: ;
      endcase
      runDownload(8'd0, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
      if ($urandom_range(2, 0) == 0) begin
        qAddr = '{int'($urandom_range(1, 0))};
        qData = '{int'($urandom_range(255, 0))};
        runDownload(8'd1, 1'($urandom_range(1, 0)), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
